// File: rtl/wino_tile_scheduler_if.sv
// ---------------------------------------------------------------------------
// wino_tile_scheduler_if
//
// Command bundle between the tile scheduler and the Winograd transform front
// ends. It carries two independent valid/ready channels:
//   weight channel : w_cmd_valid, w_cmd_ready, w_cmd_od, w_cmd_size_type
//   data channel   : d_cmd_valid, d_cmd_ready, d_cmd_x, d_cmd_y
//
// Handshake rule for both channels: a command transfers on a cycle where
// valid && ready. While valid is high and ready is low, the payload is held
// stable. At most one transfer per channel per cycle, and the scheduler never
// raises both valids in the same cycle.
//
// Modports:
//   master : scheduler side (drives valid + payload, samples ready)
//   slave  : Wtrans / Itrans side (drives ready, samples valid + payload)
// ---------------------------------------------------------------------------
interface wino_tile_scheduler_if;
    logic       w_cmd_valid;
    logic       w_cmd_ready;
    logic [7:0] w_cmd_od;
    logic       w_cmd_size_type;
    logic       d_cmd_valid;
    logic       d_cmd_ready;
    logic [8:0] d_cmd_x;
    logic [8:0] d_cmd_y;

    modport master (
        output w_cmd_valid, w_cmd_od, w_cmd_size_type,
        output d_cmd_valid, d_cmd_x, d_cmd_y,
        input  w_cmd_ready, d_cmd_ready
    );

    modport slave (
        input  w_cmd_valid, w_cmd_od, w_cmd_size_type,
        input  d_cmd_valid, d_cmd_x, d_cmd_y,
        output w_cmd_ready, d_cmd_ready
    );
endinterface

// File: rtl/wino_tile_scheduler.sv
// ---------------------------------------------------------------------------
// wino_tile_scheduler
//
// Sequences one convolution layer through the Winograd PE array. For each
// group of up to PE_COLS output channels it issues the weight tiles, then
// every spatial input tile in raster order, then waits DRAIN_CYCLES for the
// systolic pipeline to empty before the next group (or layer completion).
//
// Ports:
//   clk              clock
//   reset            asynchronous, active-high reset
//   start_i          one-cycle layer start, honoured only in IDLE
//   cfg_h_i          input height (rows)
//   cfg_w_i          input width (cols)
//   cfg_od_i         output channel count
//   cfg_size_type_i  0: 1x1 kernel, step 6; 1: 3x3 kernel, step 4
//   cmd_if           weight / data command channels (master side)
//   busy_o           high in every state except IDLE
//   done_o           one-cycle pulse at layer completion
//   state_o          current FSM state, for observation
// All outputs are registered.
// ---------------------------------------------------------------------------
module wino_tile_scheduler #(
    parameter int unsigned PE_COLS      = 4,
    parameter int unsigned DRAIN_CYCLES = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start_i,
    input  logic [8:0]                    cfg_h_i,
    input  logic [8:0]                    cfg_w_i,
    input  logic [7:0]                    cfg_od_i,
    input  logic                          cfg_size_type_i,
    wino_tile_scheduler_if.master         cmd_if,
    output logic                          busy_o,
    output logic                          done_o,
    output logic [2:0]                    state_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_W = 3'd1,
        S_STREAM = 3'd2,
        S_DRAIN  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam int unsigned CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_CYCLES - 1);

    state_t           state_q;
    logic [8:0]       cfg_h_q;
    logic [8:0]       cfg_w_q;
    logic [7:0]       cfg_od_q;
    logic             cfg_size_q;
    logic [7:0]       g_q;
    logic [7:0]       od_q;
    logic [8:0]       x_q;
    logic [8:0]       y_q;
    logic [CNT_W-1:0] cnt_q;
    logic             w_valid_q;
    logic             d_valid_q;
    logic             busy_q;
    logic             done_q;

    // Index arithmetic is one bit wider than the stored indices so that a
    // sum such as 511 + 6 cannot wrap into a small value and look in range.
    logic [9:0] step;
    logic [9:0] x_sum;
    logic [9:0] y_sum;
    logic [8:0] od_nxt;
    logic [8:0] grp_nxt;
    logic       last_w;
    logic       row_end;
    logic       col_end;
    logic       more_groups;
    logic       w_xfer;
    logic       d_xfer;

    assign step        = cfg_size_q ? 10'd4 : 10'd6;
    assign x_sum       = {1'b0, x_q} + step;
    assign y_sum       = {1'b0, y_q} + step;
    assign od_nxt      = {1'b0, od_q} + 9'd1;
    assign grp_nxt     = {1'b0, g_q} + 9'(PE_COLS);
    // Group ends at min(g + PE_COLS, cfg_od); the final group may be partial.
    assign last_w      = (od_nxt >= grp_nxt) || (od_nxt >= {1'b0, cfg_od_q});
    assign row_end     = x_sum >= {1'b0, cfg_w_q};
    assign col_end     = y_sum >= {1'b0, cfg_h_q};
    assign more_groups = grp_nxt < {1'b0, cfg_od_q};
    assign w_xfer      = w_valid_q && cmd_if.w_cmd_ready;
    assign d_xfer      = d_valid_q && cmd_if.d_cmd_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cfg_h_q    <= '0;
            cfg_w_q    <= '0;
            cfg_od_q   <= '0;
            cfg_size_q <= 1'b0;
            g_q        <= '0;
            od_q       <= '0;
            x_q        <= '0;
            y_q        <= '0;
            cnt_q      <= '0;
            w_valid_q  <= 1'b0;
            d_valid_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        cfg_h_q    <= cfg_h_i;
                        cfg_w_q    <= cfg_w_i;
                        cfg_od_q   <= cfg_od_i;
                        cfg_size_q <= cfg_size_type_i;
                        g_q        <= '0;
                        od_q       <= '0;
                        x_q        <= '0;
                        y_q        <= '0;
                        busy_q     <= 1'b1;
                        if (cfg_h_i == '0 || cfg_w_i == '0 || cfg_od_i == '0) begin
                            // Empty layer: nothing to issue, report completion.
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q   <= S_LOAD_W;
                            w_valid_q <= 1'b1;
                        end
                    end
                end

                S_LOAD_W: begin
                    if (w_xfer) begin
                        if (last_w) begin
                            w_valid_q <= 1'b0;
                            d_valid_q <= 1'b1;
                            state_q   <= S_STREAM;
                        end else begin
                            od_q <= od_nxt[7:0];
                        end
                    end
                end

                S_STREAM: begin
                    if (d_xfer) begin
                        if (row_end) begin
                            x_q <= '0;
                            if (col_end) begin
                                y_q       <= '0;
                                d_valid_q <= 1'b0;
                                cnt_q     <= '0;
                                state_q   <= S_DRAIN;
                            end else begin
                                y_q <= y_sum[8:0];
                            end
                        end else begin
                            x_q <= x_sum[8:0];
                        end
                    end
                end

                S_DRAIN: begin
                    if (cnt_q == CNT_LAST) begin
                        if (more_groups) begin
                            // more_groups implies grp_nxt < 256, so it fits 8 bits.
                            g_q       <= grp_nxt[7:0];
                            od_q      <= grp_nxt[7:0];
                            w_valid_q <= 1'b1;
                            state_q   <= S_LOAD_W;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_if.w_cmd_valid     = w_valid_q;
    assign cmd_if.w_cmd_od        = od_q;
    assign cmd_if.w_cmd_size_type = cfg_size_q;
    assign cmd_if.d_cmd_valid     = d_valid_q;
    assign cmd_if.d_cmd_x         = x_q;
    assign cmd_if.d_cmd_y         = y_q;
    assign busy_o                 = busy_q;
    assign done_o                 = done_q;
    assign state_o                = state_q;

endmodule

// File: tb/tb_wino_tile_scheduler.sv
// ---------------------------------------------------------------------------
// tb_wino_tile_scheduler
//
// Directed bench for wino_tile_scheduler. Cycle numbers are relative to the
// cycle in which start is high (cycle 0). Inputs change 1 time unit after the
// rising edge; the monitor samples on the falling edge.
// Queue entries:
//   w_exp_q : {cycle[15:0], od[7:0], size_type}
//   d_exp_q : {cycle[15:0], x[8:0], y[8:0]}
//   done_exp_q : cycle of the done pulse
// ---------------------------------------------------------------------------
module tb_wino_tile_scheduler;

    logic       clk;
    logic       reset;
    logic       start_i;
    logic [8:0] cfg_h_i;
    logic [8:0] cfg_w_i;
    logic [7:0] cfg_od_i;
    logic       cfg_size_type_i;
    logic       busy_o;
    logic       done_o;
    logic [2:0] state_o;

    wino_tile_scheduler_if cmd_if ();

    wino_tile_scheduler #(
        .PE_COLS      (4),
        .DRAIN_CYCLES (8)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start_i         (start_i),
        .cfg_h_i         (cfg_h_i),
        .cfg_w_i         (cfg_w_i),
        .cfg_od_i        (cfg_od_i),
        .cfg_size_type_i (cfg_size_type_i),
        .cmd_if          (cmd_if),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .state_o         (state_o)
    );

    // ---------------- clock / reset / cycle counter ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    int t0  = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    logic [24:0] w_exp_q[$];
    logic [33:0] d_exp_q[$];
    logic [15:0] done_exp_q[$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    task automatic push_w(input int c, input int od, input bit sz);
        w_exp_q.push_back({16'(c), 8'(od), sz});
    endtask

    task automatic push_d(input int c, input int x, input int y);
        d_exp_q.push_back({16'(c), 9'(x), 9'(y)});
    endtask

    // ---------------- monitor ----------------
    int          rel;
    logic        prev_done = 1'b0;
    logic [24:0] we;
    logic [33:0] de;

    always @(negedge clk) begin
        if (!reset) begin
            rel = cyc - t0;
            if (cmd_if.w_cmd_valid && cmd_if.d_cmd_valid)
                fail_now("both_valid");
            if (cmd_if.w_cmd_valid) begin
                if (w_exp_q.size() == 0) begin
                    fail_now("w_unexpected");
                end else begin
                    we = w_exp_q[0];
                    check("w_od", 32'(cmd_if.w_cmd_od), 32'(we[8:1]));
                    check("w_size", 32'(cmd_if.w_cmd_size_type), 32'(we[0]));
                    if (cmd_if.w_cmd_ready) begin
                        check("w_cycle", 32'(rel), 32'(we[24:9]));
                        void'(w_exp_q.pop_front());
                    end
                end
            end
            if (cmd_if.d_cmd_valid) begin
                if (d_exp_q.size() == 0) begin
                    fail_now("d_unexpected");
                end else begin
                    de = d_exp_q[0];
                    check("d_x", 32'(cmd_if.d_cmd_x), 32'(de[17:9]));
                    check("d_y", 32'(cmd_if.d_cmd_y), 32'(de[8:0]));
                    if (cmd_if.d_cmd_ready) begin
                        check("d_cycle", 32'(rel), 32'(de[33:18]));
                        void'(d_exp_q.pop_front());
                    end
                end
            end
            if (done_o) begin
                check("busy_at_done", 32'(busy_o), 32'd1);
                if (done_exp_q.size() == 0)
                    fail_now("done_unexpected");
                else
                    check("done_cycle", 32'(rel), 32'(done_exp_q.pop_front()));
            end
            if (prev_done)
                check("busy_after_done", 32'(busy_o), 32'd0);
            prev_done = done_o;
        end else begin
            prev_done = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic start_layer(input int w, input int h, input int od, input bit sz);
        @(posedge clk);
        #1;
        cfg_w_i         = 9'(w);
        cfg_h_i         = 9'(h);
        cfg_od_i        = 8'(od);
        cfg_size_type_i = sz;
        start_i         = 1'b1;
        t0              = cyc;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        // Later cfg changes must not affect the running layer.
        cfg_w_i         = 9'd3;
        cfg_h_i         = 9'd500;
        cfg_od_i        = 8'd1;
        cfg_size_type_i = ~sz;
    endtask

    task automatic wait_rel(input int n);
        while (cyc - t0 < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_done(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (w_exp_q.size() == 0 && d_exp_q.size() == 0 && done_exp_q.size() == 0)
                break;
            @(posedge clk);
            #1;
        end
        if (w_exp_q.size() != 0 || d_exp_q.size() != 0 || done_exp_q.size() != 0) begin
            fail_now({name, "_timeout"});
            w_exp_q.delete();
            d_exp_q.delete();
            done_exp_q.delete();
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_w_valid"}, 32'(cmd_if.w_cmd_valid), 32'd0);
        check({tag, "_d_valid"}, 32'(cmd_if.d_cmd_valid), 32'd0);
        check({tag, "_w_od"}, 32'(cmd_if.w_cmd_od), 32'd0);
        check({tag, "_w_size"}, 32'(cmd_if.w_cmd_size_type), 32'd0);
        check({tag, "_d_x"}, 32'(cmd_if.d_cmd_x), 32'd0);
        check({tag, "_d_y"}, 32'(cmd_if.d_cmd_y), 32'd0);
        check({tag, "_busy"}, 32'(busy_o), 32'd0);
        check({tag, "_done"}, 32'(done_o), 32'd0);
    endtask

    // Layer w=12, h=8, od=6, step 4 with ready high (hand-computed schedule).
    task automatic push_layer_12x8_od6();
        for (int i = 0; i < 4; i++) push_w(1 + i, i, 1'b1);
        push_d(5, 0, 0);  push_d(6, 4, 0);  push_d(7, 8, 0);
        push_d(8, 0, 4);  push_d(9, 4, 4);  push_d(10, 8, 4);
        push_w(19, 4, 1'b1);
        push_w(20, 5, 1'b1);
        push_d(21, 0, 0); push_d(22, 4, 0); push_d(23, 8, 0);
        push_d(24, 0, 4); push_d(25, 4, 4); push_d(26, 8, 4);
        done_exp_q.push_back(16'd35);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset                = 1'b1;
        start_i              = 1'b0;
        cfg_h_i              = '0;
        cfg_w_i              = '0;
        cfg_od_i             = '0;
        cfg_size_type_i      = 1'b0;
        cmd_if.w_cmd_ready   = 1'b1;
        cmd_if.d_cmd_ready   = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        check("rst_state", 32'(state_o), 32'd0);
        reset = 1'b0;

        // 1: full layer, ready high; a start mid-layer is ignored.
        push_layer_12x8_od6();
        start_layer(12, 8, 6, 1'b1);
        check("busy_cycle1", 32'(busy_o), 32'd1);
        wait_rel(8);
        cfg_od_i = 8'd0;
        start_i  = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        wait_done("full_layer", 200);

        // 2: step 6 with partial right edge.
        push_w(1, 0, 1'b0);
        push_d(2, 0, 0); push_d(3, 6, 0); push_d(4, 12, 0);
        done_exp_q.push_back(16'd13);
        start_layer(13, 6, 1, 1'b0);
        wait_done("step6", 200);

        // 3: back-pressure on (4,0) for three cycles.
        push_w(1, 0, 1'b1); push_w(2, 1, 1'b1);
        push_d(3, 0, 0); push_d(7, 4, 0); push_d(8, 8, 0);
        done_exp_q.push_back(16'd17);
        start_layer(12, 4, 2, 1'b1);
        wait_rel(4);
        cmd_if.d_cmd_ready = 1'b0;
        wait_rel(7);
        cmd_if.d_cmd_ready = 1'b1;
        wait_done("backpressure", 200);

        // 4: degenerate configs; a start during DONE is ignored.
        done_exp_q.push_back(16'd1);
        start_layer(12, 8, 0, 1'b1);
        wait_rel(1);
        cfg_od_i = 8'd3;
        start_i  = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        wait_done("od_zero", 50);
        done_exp_q.push_back(16'd1);
        start_layer(12, 0, 4, 1'b1);
        wait_done("h_zero", 50);

        // 5: reset in the middle of STREAM, then replay.
        push_layer_12x8_od6();
        start_layer(12, 8, 6, 1'b1);
        wait_rel(7);
        reset = 1'b1;
        #1;
        check_reset_outputs("midrst");
        w_exp_q.delete();
        d_exp_q.delete();
        done_exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        push_layer_12x8_od6();
        start_layer(12, 8, 6, 1'b1);
        wait_done("replay", 200);

        // 6: boundary width 511, step 4: x = 0..508, 128 tiles.
        push_w(1, 0, 1'b1);
        for (int i = 0; i < 128; i++) push_d(2 + i, 4 * i, 0);
        done_exp_q.push_back(16'd138);
        start_layer(511, 4, 1, 1'b1);
        wait_done("width511", 400);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/wino_tile_scheduler.md
# wino_tile_scheduler

Sequences one convolution layer through the Winograd PE array. It loads a group of weight tiles (one output channel per PE column) through the weight-transform front end, then streams every spatial input tile through the input-transform front end. It waits for the systolic pipeline to drain, then moves to the next output-channel group. It sits between the layer-control registers and the Wtrans/Itrans units that feed the array's left and top edges.

## Interface
Parameters:
- PE_COLS, 4, PE columns; number of output channels (OD) loaded per group
- DRAIN_CYCLES, 8, idle cycles after a group's last data command, before weights are reloaded or done is raised

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle layer start; ignored unless state is IDLE
- cfg_h  in  9  input height (rows)
- cfg_w  in  9  input width (cols)
- cfg_od  in  8  output channel count
- cfg_size_type  in  1  0 = 1x1 kernel / 6x6 output tile (step 6); 1 = 3x3 kernel / 4x4 output tile (step 4)
- w_cmd_valid  out  1  weight command valid
- w_cmd_ready  in  1  Wtrans accepts weight command
- w_cmd_od  out  8  OD index of weight tile
- w_cmd_size_type  out  1  latched cfg_size_type
- d_cmd_valid  out  1  data command valid
- d_cmd_ready  in  1  Itrans accepts data command
- d_cmd_x  out  9  first-column index of input tile
- d_cmd_y  out  9  first-row index of input tile
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at layer completion

## Operation
- Handshake: a command transfers on a cycle where valid && ready. While valid && !ready, the payload is held stable. At most one transfer per channel per cycle. The two channels are never valid in the same cycle.
- On accepted start, cfg_* are latched; later cfg changes have no effect until the next start. STEP = 4 if size_type = 1, else 6.
- Any of cfg_h, cfg_w, cfg_od equal to 0: go straight to DONE; no commands are issued.
- FSM states: IDLE, LOAD_W, STREAM, DRAIN, DONE.
- IDLE -> LOAD_W on start. Group base g = 0, x = y = 0.
- LOAD_W:
  - Issues OD g, g+1, …, min(g+PE_COLS, cfg_od)-1 in order. The last group may be partial.
  - After the last weight transfer -> STREAM.
- STREAM:
  - Issues (x,y) in raster order.
  - After each transfer: if x+STEP < cfg_w then x += STEP; else x = 0, and y += STEP.
  - After the transfer with x+STEP >= cfg_w and y+STEP >= cfg_h -> DRAIN, with x = y = 0.
  - Partial edge tiles are issued; padding and cropping happen downstream.
- DRAIN:
  - Counts DRAIN_CYCLES cycles.
  - At the end: if g+PE_COLS < cfg_od, then g += PE_COLS and -> LOAD_W; else -> DONE.
- DONE: done = 1 for exactly one cycle -> IDLE.
- Arithmetic: index sums are computed 1 bit wider (10 bits for x/y, 9 bits for OD), so a 511 + 6 wrap cannot cause a false continue.
- Reset mid-operation: all state clears asynchronously and the FSM returns to IDLE. An in-flight command is dropped; no done pulse.
- A start arriving during DONE or any busy state is ignored and does not queue.

## Timing
- Reset values: w_cmd_valid = 0, d_cmd_valid = 0, w_cmd_od = 0, w_cmd_size_type = 0, d_cmd_x = 0, d_cmd_y = 0, busy = 0, done = 0.
- start sampled in cycle 0 -> busy = 1 and the first command valid from cycle 1. All outputs are registered.
- With ready tied high:
  - LOAD_W lasts n_od_in_group cycles.
  - STREAM lasts ceil(cfg_w/STEP) * ceil(cfg_h/STEP) cycles.
  - DRAIN lasts DRAIN_CYCLES cycles.
  - DONE lasts 1 cycle.
- Back-pressure only stretches the state it occurs in. The DRAIN count starts the cycle after the last data transfer.
- done and the final busy cycle coincide. busy = 0 the following cycle.

## Test plan
- Full layer, ready high. PE_COLS=4, DRAIN_CYCLES=8, start@0, cfg_w=12, cfg_h=8, cfg_od=6, size_type=1.
  - Weight ODs 0..3 in cycles 1-4.
  - Data (0,0), (4,0), (8,0), (0,4), (4,4), (8,4) in cycles 5-10.
  - DRAIN in cycles 11-18.
  - ODs 4, 5 in cycles 19-20.
  - Same 6 data commands in cycles 21-26.
  - done in cycle 35 only; busy = 0 in cycle 36.
- Step 6 with partial edge. size_type=0, cfg_w=13, cfg_h=6, cfg_od=1:
  - Data x = 0, 6, 12 at y = 0 only.
  - Exactly one weight command, OD 0, with size_type 0.
- Back-pressure. Drop d_cmd_ready for 3 cycles while (4,0) is valid:
  - Payload stays (4,0) for all 3 cycles, with no duplicate or skipped tile.
  - done is delayed by exactly 3 cycles.
- Degenerate config. cfg_od=0 with start:
  - No command valid ever.
  - done pulses in cycle 1.
  - A start during busy is ignored, with no extra done.
- Reset mid-STREAM. Assert reset at cycle 7:
  - All outputs go to reset values immediately.
  - After release, a new start replays the layer from OD 0 and (0,0).
- Boundary width. cfg_w=511, cfg_h=4, size_type=1:
  - Last x = 508; 128 data tiles.
  - No wrap to a small x value.
